// File: rtl/musa_alu.sv
// MUSA execute-stage 32-bit integer ALU: combinational decode/compute, registered 35-bit result.
// Define ALU_SHIFT_EN to build the barrel shifter; without it the shift codes decode as undefined.
module musa_alu (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] op1,
  input  logic [31:0] op2,
  input  logic [5:0]  func,
  output logic [34:0] result
);

  localparam logic [5:0] FN_ADD  = 6'b100000;
  localparam logic [5:0] FN_ADDU = 6'b100001;
  localparam logic [5:0] FN_SUB  = 6'b100010;
  localparam logic [5:0] FN_SUBU = 6'b100011;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_XOR  = 6'b100110;
  localparam logic [5:0] FN_NOR  = 6'b100111;
  localparam logic [5:0] FN_SLT  = 6'b101010;
  localparam logic [5:0] FN_SLTU = 6'b101011;
`ifdef ALU_SHIFT_EN
  localparam logic [5:0] FN_SLL  = 6'b000000;
  localparam logic [5:0] FN_SRL  = 6'b000010;
  localparam logic [5:0] FN_SRA  = 6'b000011;
  localparam logic [5:0] FN_SLLV = 6'b000100;
  localparam logic [5:0] FN_SRLV = 6'b000110;
  localparam logic [5:0] FN_SRAV = 6'b000111;
`endif

  logic [31:0] w_sum;
  logic [31:0] w_diff;
  logic        w_above;
  logic        w_equals;
  logic        w_addOvf;
  logic        w_subOvf;
  logic [31:0] w_data;
  logic        w_overflow;
  logic [34:0] r_result;

  assign w_sum    = op1 + op2;
  assign w_diff   = op1 - op2;
  assign w_above  = $signed(op1) > $signed(op2);
  assign w_equals = (op1 == op2);
  assign w_addOvf = (op1[31] == op2[31]) && (w_sum[31] != op1[31]);
  assign w_subOvf = (op1[31] != op2[31]) && (w_diff[31] != op1[31]);

`ifdef ALU_SHIFT_EN
  logic [4:0]  w_shamt;
  logic [31:0] w_sll;
  logic [31:0] w_srl;
  logic [31:0] w_sra;

  assign w_shamt = op2[4:0];
  assign w_sll   = op1 << w_shamt;
  assign w_srl   = op1 >> w_shamt;
  assign w_sra   = $unsigned($signed(op1) >>> w_shamt);
`endif

  // Overflow is only a flag; the data field always carries the wrapped value.
  always_comb begin
    w_data     = 32'h0;
    w_overflow = 1'b0;
    case (func)
      FN_ADD: begin
        w_data     = w_sum;
        w_overflow = w_addOvf;
      end
      FN_ADDU: w_data = w_sum;
      FN_SUB: begin
        w_data     = w_diff;
        w_overflow = w_subOvf;
      end
      FN_SUBU: w_data = w_diff;
      FN_AND:  w_data = op1 & op2;
      FN_OR:   w_data = op1 | op2;
      FN_XOR:  w_data = op1 ^ op2;
      FN_NOR:  w_data = ~(op1 | op2);
      FN_SLT:  w_data = {31'h0, $signed(op1) < $signed(op2)};
      FN_SLTU: w_data = {31'h0, op1 < op2};
`ifdef ALU_SHIFT_EN
      FN_SLL, FN_SLLV: w_data = w_sll;
      FN_SRL, FN_SRLV: w_data = w_srl;
      FN_SRA, FN_SRAV: w_data = w_sra;
`endif
      default: w_data = 32'h0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_result <= 35'h0;
    end else begin
      r_result <= {w_overflow, w_equals, w_above, w_data};
    end
  end

  assign result = r_result;

endmodule

// File: tb/tb_musa_alu.sv
// Self-checking bench for musa_alu: directed vector table plus reset and back-to-back ADD sequences.
// Shift expectations follow ALU_SHIFT_EN so the bench matches either build.
module tb_musa_alu;

  logic        clk;
  logic        rst;
  logic [31:0] op1;
  logic [31:0] op2;
  logic [5:0]  func;
  logic [34:0] result;

  int checks;
  int passes;

  typedef struct {
    string       name;
    logic [31:0] a;
    logic [31:0] b;
    logic [5:0]  fn;
    logic [34:0] exp;
  } vec_t;

  vec_t vecs[$];

  musa_alu dut (
    .clk    (clk),
    .rst    (rst),
    .op1    (op1),
    .op2    (op2),
    .func   (func),
    .result (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input logic [5:0] fn);
    op1  = a;
    op2  = b;
    func = fn;
  endtask

  task automatic checkOutput(input string name, input logic [34:0] exp);
    checks++;
    if (result === exp) begin
      passes++;
    end else begin
      $display("[TB] FAIL %s: got 35'h%09h, expected 35'h%09h", name, result, exp);
    end
  endtask

  function automatic void addVec(input string name, input logic [31:0] a, input logic [31:0] b,
                                 input logic [5:0] fn, input logic [34:0] exp);
    vec_t v;
    v.name = name;
    v.a    = a;
    v.b    = b;
    v.fn   = fn;
    v.exp  = exp;
    vecs.push_back(v);
  endfunction

  function automatic logic [34:0] addModel(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] wide;
    logic        ovf;
    logic        abv;
    wide = {a[31], a} + {b[31], b};
    ovf  = wide[32] != wide[31];
    abv  = $signed(a) > $signed(b);
    return {ovf, a == b, abv, wide[31:0]};
  endfunction

  initial begin
    checks = 0;
    passes = 0;

    addVec("add_ovf",     32'h7FFFFFFF, 32'h00000001, 6'b100000, 35'h5_80000000);
    addVec("addu_noovf",  32'h7FFFFFFF, 32'h00000001, 6'b100001, 35'h1_80000000);
    addVec("sub_neg",     32'hFFFFFFFD, 32'h00000004, 6'b100010, 35'h0_FFFFFFF9);
    addVec("slt",         32'hFFFFFFFD, 32'h00000004, 6'b101010, 35'h0_00000001);
    addVec("sltu",        32'hFFFFFFFD, 32'h00000004, 6'b101011, 35'h0_00000000);
    addVec("sltu_true",   32'h00000001, 32'hFFFFFFFF, 6'b101011, 35'h1_00000001);
    addVec("slt_eq",      32'h00000005, 32'h00000005, 6'b101010, 35'h2_00000000);
    addVec("nor",         32'hF0F0F0F0, 32'h0FF00FF0, 6'b100111, 35'h0_000F000F);
    addVec("and",         32'hF0F0F0F0, 32'h0FF00FF0, 6'b100100, 35'h0_00F000F0);
    addVec("or",          32'hF0F0F0F0, 32'h0FF00FF0, 6'b100101, 35'h0_FFF0FFF0);
    addVec("xor",         32'hF0F0F0F0, 32'h0FF00FF0, 6'b100110, 35'h0_FF00FF00);
    addVec("sub_ovf",     32'h80000000, 32'h00000001, 6'b100010, 35'h4_7FFFFFFF);
    addVec("subu_noovf",  32'h80000000, 32'h00000001, 6'b100011, 35'h0_7FFFFFFF);
    addVec("add_neg_eq",  32'hFFFFFFFF, 32'hFFFFFFFF, 6'b100000, 35'h2_FFFFFFFE);
    addVec("add_neg_ovf", 32'h80000000, 32'h80000000, 6'b100000, 35'h6_00000000);
    addVec("undef_eq",    32'h00000005, 32'h00000005, 6'b111111, 35'h2_00000000);
    addVec("undef_above", 32'h00000009, 32'h00000002, 6'b111111, 35'h1_00000000);
`ifdef ALU_SHIFT_EN
    addVec("sra",  32'h80000000, 32'h00000004, 6'b000011, 35'h0_F8000000);
    addVec("srl",  32'h80000000, 32'h00000004, 6'b000010, 35'h0_08000000);
    addVec("sll",  32'h00000001, 32'h0000001F, 6'b000000, 35'h0_80000000);
    addVec("srlv", 32'hF0000000, 32'h00000024, 6'b000110, 35'h0_0F000000);
    addVec("sllv", 32'h00000003, 32'h00000002, 6'b000100, 35'h1_0000000C);
    addVec("srav", 32'hF0000000, 32'h00000008, 6'b000111, 35'h0_FFF00000);
`else
    addVec("sra",  32'h80000000, 32'h00000004, 6'b000011, 35'h0_00000000);
    addVec("srl",  32'h80000000, 32'h00000004, 6'b000010, 35'h0_00000000);
    addVec("sll",  32'h00000001, 32'h0000001F, 6'b000000, 35'h0_00000000);
    addVec("srlv", 32'hF0000000, 32'h00000024, 6'b000110, 35'h0_00000000);
    addVec("sllv", 32'h00000003, 32'h00000002, 6'b000100, 35'h1_00000000);
    addVec("srav", 32'hF0000000, 32'h00000008, 6'b000111, 35'h0_00000000);
`endif

    // Reset held from time zero with live operands: output must stay cleared.
    rst = 1'b1;
    applyStimulus(32'd5, 32'd5, 6'b100000);
    #1;
    checkOutput("reset_immediate", 35'h0);
    @(posedge clk);
    #1;
    checkOutput("reset_held", 35'h0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("first_after_reset", 35'h2_0000000A);

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].a, vecs[i].b, vecs[i].fn);
      @(posedge clk);
      #1;
      checkOutput(vecs[i].name, vecs[i].exp);
    end

    // Mid-stream async reset clears a nonzero result and drops the pending op.
    applyStimulus(32'h7FFFFFFF, 32'h00000001, 6'b100000);
    @(posedge clk);
    #1;
    checkOutput("pre_reset_load", 35'h5_80000000);
    applyStimulus(32'h00000003, 32'h00000004, 6'b100000);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("midstream_reset_async", 35'h0);
    @(posedge clk);
    #1;
    checkOutput("midstream_reset_discard", 35'h0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("resume_after_reset", 35'h0_00000007);

    // Back-to-back random ADDs, one per cycle, each checked one cycle later.
    for (int i = 0; i < 10; i++) begin
      logic [31:0] a;
      logic [31:0] b;
      a = $urandom;
      b = (i == 3) ? a : $urandom;
      applyStimulus(a, b, 6'b100000);
      @(posedge clk);
      #1;
      checkOutput($sformatf("rand_add_%0d", i), addModel(a, b));
    end

    applyStimulus(32'h12345678, 32'h00000001, 6'b111111);
    @(posedge clk);
    #1;
    checkOutput("undef_111111", 35'h1_00000000);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
